// File: rtl/nic_defs.sv
`default_nettype none
// ============================================================================
//  Module      : nic_defs (package)
//  Description : Beat layout constants and RX framer state encoding shared by
//                the NIC UDP TX packetizer and RX depacketizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package nic_defs;

    localparam int MAC_W         = 48;
    localparam int ETH_HDR_BYTES = 14;

    // Header fields on the SOP beat
    localparam int DST_HI        = 255;
    localparam int DST_LO        = 208;
    localparam int LEN_HI        = 159;
    localparam int LEN_LO        = 144;

    // Payload slices carried by each beat
    localparam int SOP_PLOAD_HI  = 143;
    localparam int MID_PLOAD_LO  = 144;
    localparam int MID_PLOAD_HI  = 399;
    localparam int EOP_PLOAD_LO  = 400;
    localparam int EOP_PLOAD_HI  = 511;
    localparam int EOP_BEAT_BITS = EOP_PLOAD_HI - EOP_PLOAD_LO + 1;

    localparam logic [4:0] EOP_EMPTY = 5'd18;

    typedef enum logic [2:0] {
        RxIdle  = 3'd0,
        RxData  = 3'd1,
        RxEop   = 3'd2,
        RxDrain = 3'd3,
        RxOut   = 3'd4
    } rx_state_e;

endpackage : nic_defs
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count one event per cycle, holding once every bit is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/udp_rx_depacketizer.sv
`default_nettype none
// ============================================================================
//  Module      : udp_rx_depacketizer
//  Description : Reassembles 3-beat 256-bit Avalon-ST frames into a 512-bit
//                payload, filtering on dst MAC, length, framing and MAC error,
//                with saturating statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_rx_depacketizer
    import nic_defs::*;
#(
    parameter logic [47:0] LOCAL_MAC        = 48'h000000000000,
    parameter bit          ACCEPT_BROADCAST = 1'b1,
    parameter logic [15:0] EXPECTED_LEN     = 16'd64,
    parameter int          CNT_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [255:0]         rx_data_in,
    input  logic                 rx_valid_in,
    input  logic                 rx_sop_in,
    input  logic                 rx_eop_in,
    input  logic [4:0]           rx_empty_in,
    input  logic [5:0]           rx_error_in,
    output logic                 rx_ready_out,
    output logic [511:0]         pload_out,
    output logic                 pload_valid_out,
    input  logic                 pload_ready_in,
    output logic [CNT_WIDTH-1:0] cnt_ok_out,
    output logic [CNT_WIDTH-1:0] cnt_frame_err_out,
    output logic [CNT_WIDTH-1:0] cnt_mac_drop_out,
    output logic [CNT_WIDTH-1:0] cnt_len_drop_out,
    output logic [CNT_WIDTH-1:0] cnt_phy_err_out
);

    rx_state_e    state_q, state_d;
    logic         rx_ready_q;
    logic         pload_valid_q;
    logic [511:0] pload_q;
    logic         mac_bad_q;
    logic         len_bad_q;

    logic         beat_acc;
    logic         lat_sop, lat_mid, lat_eop;
    logic         inc_ok, inc_frame, inc_mac, inc_len, inc_phy;
    logic [MAC_W-1:0] sop_dst;
    logic         sop_mac_bad;
    logic         sop_len_bad;

    assign beat_acc    = rx_valid_in & rx_ready_q;
    assign sop_dst     = rx_data_in[DST_HI:DST_LO];
    assign sop_mac_bad = (sop_dst != LOCAL_MAC) &&
                         !(ACCEPT_BROADCAST && (sop_dst == {MAC_W{1'b1}}));
    assign sop_len_bad = (rx_data_in[LEN_HI:LEN_LO] != EXPECTED_LEN);

    // Next-state and counter-event decode for the accepted beat
    always_comb begin
        state_d   = state_q;
        lat_sop   = 1'b0;
        lat_mid   = 1'b0;
        lat_eop   = 1'b0;
        inc_ok    = 1'b0;
        inc_frame = 1'b0;
        inc_mac   = 1'b0;
        inc_len   = 1'b0;
        inc_phy   = 1'b0;
        if (beat_acc) begin
            case (state_q)
                RxIdle, RxData, RxEop, RxDrain: begin
                    if (rx_sop_in) begin
                        // An SOP mid-frame aborts the frame, then restarts on it
                        if ((state_q == RxData) || (state_q == RxEop))
                            inc_frame = 1'b1;
                        if (rx_eop_in) begin
                            inc_frame = 1'b1;
                            state_d   = (state_q == RxDrain) ? RxDrain : RxIdle;
                        end else begin
                            lat_sop = 1'b1;
                            state_d = RxData;
                        end
                    end else begin
                        case (state_q)
                            RxIdle: begin
                                inc_frame = 1'b1;
                                state_d   = rx_eop_in ? RxIdle : RxDrain;
                            end
                            RxData: begin
                                if (rx_eop_in) begin
                                    inc_frame = 1'b1;
                                    state_d   = RxIdle;
                                end else begin
                                    lat_mid = 1'b1;
                                    state_d = RxEop;
                                end
                            end
                            RxEop: begin
                                if (!rx_eop_in) begin
                                    inc_frame = 1'b1;
                                    state_d   = RxDrain;
                                end else begin
                                    lat_eop = 1'b1;
                                    state_d = RxIdle;
                                    if (rx_error_in != 6'd0)          inc_phy   = 1'b1;
                                    else if (rx_empty_in != EOP_EMPTY) inc_frame = 1'b1;
                                    else if (mac_bad_q)                inc_mac   = 1'b1;
                                    else if (len_bad_q)                inc_len   = 1'b1;
                                    else begin
                                        inc_ok  = 1'b1;
                                        state_d = RxOut;
                                    end
                                end
                            end
                            default: begin
                                if (rx_eop_in) state_d = RxIdle;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
        if ((state_q == RxOut) && pload_ready_in)
            state_d = RxIdle;
    end

    // State, registered handshakes, per-frame flags and payload assembly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RxIdle;
            rx_ready_q    <= 1'b0;
            pload_valid_q <= 1'b0;
            pload_q       <= '0;
            mac_bad_q     <= 1'b0;
            len_bad_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_ready_q    <= (state_d != RxOut);
            pload_valid_q <= (state_d == RxOut);
            if (lat_sop) begin
                pload_q[SOP_PLOAD_HI:0] <= rx_data_in[SOP_PLOAD_HI:0];
                mac_bad_q               <= sop_mac_bad;
                len_bad_q               <= sop_len_bad;
            end
            if (lat_mid)
                pload_q[MID_PLOAD_HI:MID_PLOAD_LO] <= rx_data_in;
            if (lat_eop)
                pload_q[EOP_PLOAD_HI:EOP_PLOAD_LO] <= rx_data_in[EOP_BEAT_BITS-1:0];
        end
    end

    assign rx_ready_out    = rx_ready_q;
    assign pload_valid_out = pload_valid_q;
    assign pload_out       = pload_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_ok (
        .clk(clk), .rst_n(reset_n), .inc_i(inc_ok), .count_o(cnt_ok_out));
    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_frame (
        .clk(clk), .rst_n(reset_n), .inc_i(inc_frame), .count_o(cnt_frame_err_out));
    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_mac (
        .clk(clk), .rst_n(reset_n), .inc_i(inc_mac), .count_o(cnt_mac_drop_out));
    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_len (
        .clk(clk), .rst_n(reset_n), .inc_i(inc_len), .count_o(cnt_len_drop_out));
    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_phy (
        .clk(clk), .rst_n(reset_n), .inc_i(inc_phy), .count_o(cnt_phy_err_out));

endmodule : udp_rx_depacketizer
`default_nettype wire
